// File: rtl/updown_tick_counter_if.sv
// rtl/updown_tick_counter_if.sv - control and status bundle for the up/down tick counter
interface updown_tick_counter_if #(
  parameter int WIDTH = 4
);
  logic             enable;
  logic             clear;
  logic             mode;
  logic             wrap_en;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] count_reg;
  logic             o_tick;
  logic             o_carry;
  logic             o_at_limit;

  modport master (
    output enable, clear, mode, wrap_en, load, load_value,
    input  count_reg, o_tick, o_carry, o_at_limit
  );

  modport slave (
    input  enable, clear, mode, wrap_en, load, load_value,
    output count_reg, o_tick, o_carry, o_at_limit
  );
endinterface

// File: rtl/updown_tick_counter.sv
// rtl/updown_tick_counter.sv - prescaled up/down counter with wrap/hold, load and clear
module updown_tick_counter #(
  parameter int TICK_CYCLE = 10_000,
  parameter int MODULUS    = 10_000,
  parameter int WIDTH      = $clog2(MODULUS)
) (
  input  logic                  clk,
  input  logic                  rst,
  updown_tick_counter_if.slave  bus
);
  localparam int PW = (TICK_CYCLE > 2) ? $clog2(TICK_CYCLE) : 1;

  localparam logic [PW-1:0]    PRE_LAST = PW'(TICK_CYCLE - 1);
  localparam logic [WIDTH-1:0] LAST     = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_W    = (WIDTH + 1)'(MODULUS);

  logic [PW-1:0]    pre_cnt;
  logic [WIDTH-1:0] count;
  logic             tick_q;
  logic             carry_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt <= '0;
      count   <= '0;
      tick_q  <= 1'b0;
      carry_q <= 1'b0;
    end else if (bus.clear) begin
      pre_cnt <= '0;
      count   <= '0;
      tick_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      tick_q  <= 1'b0;
      carry_q <= 1'b0;
      if (bus.enable) begin
        if (pre_cnt == PRE_LAST) begin
          pre_cnt <= '0;
          tick_q  <= 1'b1;
        end else begin
          pre_cnt <= pre_cnt + PW'(1);
        end
      end
      // A load swallows a coinciding step; the prescaler keeps its cadence.
      if (bus.load) begin
        count <= ({1'b0, bus.load_value} >= MOD_W) ? LAST : bus.load_value;
      end else if (tick_q) begin
        if (!bus.mode) begin
          if (count == LAST) begin
            if (bus.wrap_en) begin
              count   <= '0;
              carry_q <= 1'b1;
            end
          end else begin
            count <= count + WIDTH'(1);
          end
        end else begin
          if (count == '0) begin
            if (bus.wrap_en) begin
              count   <= LAST;
              carry_q <= 1'b1;
            end
          end else begin
            count <= count - WIDTH'(1);
          end
        end
      end
    end
  end

  assign bus.count_reg  = count;
  assign bus.o_tick     = tick_q;
  assign bus.o_carry    = carry_q;
  assign bus.o_at_limit = bus.mode ? (count == '0) : (count == LAST);
endmodule

// File: tb/tb_updown_tick_counter.sv
// tb/tb_updown_tick_counter.sv - directed self-checking bench for updown_tick_counter
module tb_updown_tick_counter;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  updown_tick_counter_if #(.WIDTH(4)) bus ();

  updown_tick_counter #(
    .TICK_CYCLE(4),
    .MODULUS   (10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    cyc();
    bus.clear = 1'b0;
  endtask

  task automatic do_load(input logic [3:0] v);
    bus.load       = 1'b1;
    bus.load_value = v;
    cyc();
    bus.load       = 1'b0;
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    rst            = 1'b1;
    bus.enable     = 1'b0;
    bus.clear      = 1'b0;
    bus.mode       = 1'b0;
    bus.wrap_en    = 1'b1;
    bus.load       = 1'b0;
    bus.load_value = 4'd0;
    #2;
    check("rst_count", 32'(bus.count_reg), 0);
    check("rst_tick", 32'(bus.o_tick), 0);
    check("rst_carry", 32'(bus.o_carry), 0);
    check("rst_limit_up", 32'(bus.o_at_limit), 0);
    bus.mode = 1'b1;
    #1;
    check("rst_limit_down", 32'(bus.o_at_limit), 1);
    bus.mode = 1'b0;
    @(negedge clk);
    rst        = 1'b0;
    bus.enable = 1'b1;

    // free run up with wrap: 84 edges cover two full wraps
    for (int k = 1; k <= 84; k++) begin
      cyc();
      check($sformatf("run_tick_%0d", k), 32'(bus.o_tick), (k % 4 == 0) ? 1 : 0);
      check($sformatf("run_count_%0d", k), 32'(bus.count_reg), ((k - 1) / 4) % 10);
      check($sformatf("run_carry_%0d", k), 32'(bus.o_carry), (k % 40 == 1 && k > 1) ? 1 : 0);
    end

    // down, hold at 0
    do_clear();
    bus.mode    = 1'b1;
    bus.wrap_en = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      check($sformatf("dhold_count_%0d", k), 32'(bus.count_reg), 0);
      check($sformatf("dhold_carry_%0d", k), 32'(bus.o_carry), 0);
      check($sformatf("dhold_limit_%0d", k), 32'(bus.o_at_limit), 1);
    end

    // down, wrap from 0 to 9
    do_clear();
    bus.wrap_en = 1'b1;
    repeat (4) cyc();
    check("dwrap_tick", 32'(bus.o_tick), 1);
    cyc();
    check("dwrap_count", 32'(bus.count_reg), 9);
    check("dwrap_carry", 32'(bus.o_carry), 1);
    cyc();
    check("dwrap_carry_once", 32'(bus.o_carry), 0);

    // up, hold at 9 (load clamps 12 to 9)
    do_clear();
    bus.mode    = 1'b0;
    bus.wrap_en = 1'b0;
    do_load(4'd12);
    check("clamp_count", 32'(bus.count_reg), 9);
    for (int k = 1; k <= 8; k++) begin
      cyc();
      check($sformatf("uhold_count_%0d", k), 32'(bus.count_reg), 9);
      check($sformatf("uhold_carry_%0d", k), 32'(bus.o_carry), 0);
      check($sformatf("uhold_limit_%0d", k), 32'(bus.o_at_limit), 1);
    end

    // load coinciding with a step
    do_clear();
    bus.wrap_en = 1'b1;
    do_load(4'd9);
    repeat (3) cyc();
    check("ldstep_tick", 32'(bus.o_tick), 1);
    check("ldstep_pre_count", 32'(bus.count_reg), 9);
    do_load(4'd12);
    check("ldstep_count", 32'(bus.count_reg), 9);
    check("ldstep_carry", 32'(bus.o_carry), 0);
    repeat (3) cyc();
    check("ldstep_cadence", 32'(bus.o_tick), 1);
    cyc();
    check("ldstep_next_count", 32'(bus.count_reg), 0);
    check("ldstep_next_carry", 32'(bus.o_carry), 1);

    // clear beats load, and beats an imminent tick
    do_clear();
    do_load(4'd5);
    repeat (2) cyc();
    check("clrld_pre_count", 32'(bus.count_reg), 5);
    bus.clear      = 1'b1;
    bus.load       = 1'b1;
    bus.load_value = 4'd3;
    cyc();
    bus.clear = 1'b0;
    bus.load  = 1'b0;
    check("clrld_count", 32'(bus.count_reg), 0);
    check("clrld_pre", 32'(dut.pre_cnt), 0);
    check("clrld_tick", 32'(bus.o_tick), 0);

    // enable gap with the prescaler at 2
    do_clear();
    repeat (2) cyc();
    check("gap_pre_before", 32'(dut.pre_cnt), 2);
    bus.enable = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      cyc();
      check($sformatf("gap_tick_%0d", k), 32'(bus.o_tick), 0);
    end
    check("gap_pre_held", 32'(dut.pre_cnt), 2);
    bus.enable = 1'b1;
    cyc();
    check("gap_tick_after1", 32'(bus.o_tick), 0);
    cyc();
    check("gap_tick_after2", 32'(bus.o_tick), 1);

    // asynchronous reset mid-count with a pending tick
    do_clear();
    do_load(4'd7);
    repeat (3) cyc();
    check("arst_pre_tick", 32'(bus.o_tick), 1);
    check("arst_pre_count", 32'(bus.count_reg), 7);
    #2 rst = 1'b1;
    #1;
    check("arst_count", 32'(bus.count_reg), 0);
    check("arst_tick", 32'(bus.o_tick), 0);
    check("arst_carry", 32'(bus.o_carry), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      check($sformatf("arst_rel_tick_%0d", k), 32'(bus.o_tick), (k == 4) ? 1 : 0);
      check($sformatf("arst_rel_count_%0d", k), 32'(bus.count_reg), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/updown_tick_counter.md
UPDOWN_TICK_COUNTER -- requirements
Module: updown_tick_counter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- TICK_CYCLE, 10_000, clock cycles per count step; legal range >= 2.
- MODULUS, 10_000, count range 0..MODULUS-1; legal range >= 2.
- WIDTH, $clog2(MODULUS), count width; derived, never overridden.
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- enable  input  1  prescaler run; low freezes the prescaler.
- clear  input  1  synchronous clear of the prescaler, count and pulses.
- mode  input  1  0 = count up, 1 = count down.
- wrap_en  input  1  1 = wrap at terminal value, 0 = hold at terminal value.
- load  input  1  synchronous load of load_value into count.
- load_value  input  WIDTH  value to load.
- count_reg  output  WIDTH  current count.
- o_tick  output  1  one-cycle prescaler pulse.
- o_carry  output  1  one-cycle wrap pulse (up or down).
- o_at_limit  output  1  count is at the terminal value for the current mode.

Function
REQ-003 The internal prescaler pre_cnt SHALL span 0..TICK_CYCLE-1 and SHALL advance only on edges where enable=1.
REQ-004 On an edge where enable=1 and pre_cnt=TICK_CYCLE-1, pre_cnt SHALL return to 0 and o_tick SHALL be registered high for exactly the next cycle; on every other edge o_tick SHALL be registered 0.
REQ-005 The first o_tick after reset with enable held high SHALL be high during the cycle after the TICK_CYCLE-th rising edge; after that, o_tick SHALL pulse every TICK_CYCLE cycles.
REQ-006 With enable=0, pre_cnt SHALL hold its value and o_tick SHALL be 0.
REQ-007 count_reg SHALL step by one on the edge where o_tick=1, giving a one-cycle latency from o_tick to the count change.
REQ-008 In up mode, a step at count MODULUS-1 SHALL give 0 with o_carry high for one cycle when wrap_en=1, and SHALL hold MODULUS-1 with o_carry 0 when wrap_en=0.
REQ-009 In down mode, a step at count 0 SHALL give MODULUS-1 with o_carry high for one cycle when wrap_en=1, and SHALL hold 0 with o_carry 0 when wrap_en=0.
REQ-010 o_carry SHALL be registered and SHALL never be high for more than one consecutive cycle.
REQ-011 o_at_limit SHALL be combinational: (mode=0 and count_reg=MODULUS-1) or (mode=1 and count_reg=0).
REQ-012 clear SHALL have top priority and SHALL set pre_cnt, count_reg, o_tick and o_carry to 0 on the next edge, regardless of enable.
REQ-013 load SHALL rank below clear and above a step; it SHALL set count_reg to load_value, or to MODULUS-1 if load_value >= MODULUS.
REQ-014 A step coinciding with load SHALL be discarded, and o_carry SHALL be 0 on that edge.
REQ-015 load SHALL leave pre_cnt and the o_tick cadence unchanged.
REQ-016 A change of mode or wrap_en SHALL take effect at the next step; no pending step SHALL be lost or duplicated.
REQ-017 count_reg SHALL never hold a value >= MODULUS.

Reset
REQ-018 rst=1 SHALL immediately, without a clock edge, force pre_cnt=0, count_reg=0, o_tick=0 and o_carry=0.
REQ-019 o_at_limit SHALL follow REQ-011 during reset: 1 when mode=1, 0 when mode=0.
REQ-020 Reset asserted mid-count SHALL discard any pending tick; after release, the first o_tick SHALL follow REQ-005.

Verification (TICK_CYCLE=4, MODULUS=10)
REQ-021 Reset, enable=1, mode=0, wrap_en=1 -> o_tick pulses every 4 cycles; count_reg runs 0..9, then 0 with one o_carry pulse; this repeats.
REQ-022 mode=1, wrap_en=0, count_reg=0 -> count_reg holds 0, o_at_limit=1, o_carry never high.
REQ-023 load=1 with load_value=12 in the same cycle as o_tick=1 -> count_reg=9 next cycle, no step, o_carry=0.
REQ-024 clear=1 and load=1 together with count_reg=5 -> count_reg=0, pre_cnt=0, o_tick=0 next cycle.
REQ-025 enable dropped for 7 cycles with pre_cnt=2 -> no o_tick during the gap; the next o_tick comes 2 enabled cycles after enable returns.
REQ-026 rst pulsed asynchronously between edges with count_reg=7 -> count_reg=0 and o_tick=0 immediately, before the next edge.
